// File: rtl/taus_stream_checker.sv
// Receive-side checker for a Tausworthe URNG stream. It regenerates the expected
// sequence from the same seeds and records mismatch statistics for the received samples.
module taus_stream_checker #(
  parameter int CNT_W     = 16,
  parameter int READY_GAP = 0
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [31:0]      iUrng_seed1,
  input  logic [31:0]      iUrng_seed2,
  input  logic [31:0]      iUrng_seed3,
  input  logic [CNT_W-1:0] iNumSamples,
  input  logic [31:0]      iTaus,
  input  logic             iValid,
  output logic             oReady,
  output logic             oBusy,
  output logic             oDone,
  output logic             oSeedErr,
  output logic [CNT_W-1:0] oMismatchCnt,
  output logic [CNT_W-1:0] oFirstErrIdx,
  output logic [31:0]      oFirstErrExp,
  output logic [31:0]      oFirstErrGot,
  output logic             oErrValid
);

  localparam int GAP_W = (READY_GAP > 1) ? $clog2(READY_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [31:0]      first_exp_q, first_exp_d;
  logic [31:0]      first_got_q, first_got_d;
  logic             err_valid_q, err_valid_d;
  logic             done_q, done_d;
  logic             seed_err_q, seed_err_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             stall_q, stall_d;

  logic [31:0] b1, b2, b3, n1, n2, n3, exp_val;
  logic        seeds_ok, xfer;

  always_comb begin
    b1 = ((s1_q << 13) ^ s1_q) >> 19;
    n1 = ((s1_q & 32'hFFFF_FFFE) << 12) ^ b1;
    b2 = ((s2_q << 2) ^ s2_q) >> 25;
    n2 = ((s2_q & 32'hFFFF_FFF8) << 4) ^ b2;
    b3 = ((s3_q << 3) ^ s3_q) >> 11;
    n3 = ((s3_q & 32'hFFFF_FFF0) << 17) ^ b3;
    exp_val = n1 ^ n2 ^ n3;
  end

  assign seeds_ok = (iUrng_seed1 > 32'd1) && (iUrng_seed2 > 32'd7) && (iUrng_seed3 > 32'd15);
  assign xfer     = (state_q == S_RUN) && iValid && !stall_q;

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    count_d     = count_q;
    idx_d       = idx_q;
    mism_d      = mism_q;
    first_idx_d = first_idx_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    err_valid_d = err_valid_q;
    done_d      = done_q;
    seed_err_d  = seed_err_q;
    gap_cnt_d   = gap_cnt_q;
    stall_d     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          if (!seeds_ok) begin
            seed_err_d = 1'b1;
          end else begin
            // Seeds and count are captured here so the start pulse need not be held.
            state_d     = S_LOAD;
            s1_d        = iUrng_seed1;
            s2_d        = iUrng_seed2;
            s3_d        = iUrng_seed3;
            count_d     = iNumSamples;
            idx_d       = '0;
            mism_d      = '0;
            first_idx_d = '0;
            first_exp_d = '0;
            first_got_d = '0;
            err_valid_d = 1'b0;
            done_d      = 1'b0;
            seed_err_d  = 1'b0;
            gap_cnt_d   = '0;
          end
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (xfer) begin
          s1_d  = n1;
          s2_d  = n2;
          s3_d  = n3;
          idx_d = idx_q + CNT_W'(1);
          if (iTaus != exp_val) begin
            if (!(&mism_q)) mism_d = mism_q + CNT_W'(1);
            if (!err_valid_q) begin
              first_idx_d = idx_q;
              first_exp_d = exp_val;
              first_got_d = iTaus;
              err_valid_d = 1'b1;
            end
          end
          // A count of zero wraps to all-ones here, giving 2^CNT_W samples.
          if (idx_q == (count_q - CNT_W'(1))) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
          if (READY_GAP != 0) begin
            if (gap_cnt_q == GAP_W'(READY_GAP - 1)) begin
              gap_cnt_d = '0;
              stall_d   = 1'b1;
            end else begin
              gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= S_IDLE;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      mism_q      <= '0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
      err_valid_q <= 1'b0;
      done_q      <= 1'b0;
      seed_err_q  <= 1'b0;
      gap_cnt_q   <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      mism_q      <= mism_d;
      first_idx_q <= first_idx_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      err_valid_q <= err_valid_d;
      done_q      <= done_d;
      seed_err_q  <= seed_err_d;
      gap_cnt_q   <= gap_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign oReady       = (state_q == S_RUN) && !stall_q;
  assign oBusy        = (state_q == S_LOAD) || (state_q == S_RUN);
  assign oDone        = done_q;
  assign oSeedErr     = seed_err_q;
  assign oMismatchCnt = mism_q;
  assign oFirstErrIdx = first_idx_q;
  assign oFirstErrExp = first_exp_q;
  assign oFirstErrGot = first_got_q;
  assign oErrValid    = err_valid_q;

endmodule

// File: doc/taus_stream_checker.md
Name: taus_stream_checker

Overview:
- Receiving end of the Tausworthe URNG stream: consumes 32-bit samples from a taus generator over a valid/ready handshake.
- Regenerates the expected sequence internally from the same three seeds and compares each received sample against it.
- Reports mismatch count, first-error index and value, and a done flag after a programmed sample count.
- Sits downstream of the dual taus generator top, one instance per stream, for on-chip self-check before vectors are dumped for MATLAB.

Parameters:
CNT_W, 16, width of sample counter and mismatch counter
READY_GAP, 0, when nonzero oReady deasserts for one cycle after every READY_GAP accepted samples (backpressure test mode)

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  asynchronous active-low reset
iStart  in  1  one-cycle pulse: latch seeds and sample count, begin check
iUrng_seed1  in  32  seed s1 (must be >1)
iUrng_seed2  in  32  seed s2 (must be >7)
iUrng_seed3  in  32  seed s3 (must be >15)
iNumSamples  in  CNT_W  samples to check; 0 treated as 2^CNT_W
iTaus  in  32  received sample
iValid  in  1  iTaus valid
oReady  out  1  checker accepts iTaus this cycle
oBusy  out  1  in LOAD or RUN
oDone  out  1  sticky, set when iNumSamples samples accepted
oSeedErr  out  1  sticky, set on iStart with illegal seeds
oMismatchCnt  out  CNT_W  number of mismatching samples, saturating
oFirstErrIdx  out  CNT_W  index (0-based) of first mismatch
oFirstErrExp  out  32  expected value at first mismatch
oFirstErrGot  out  32  received value at first mismatch
oErrValid  out  1  sticky, first-error registers hold valid data

Behaviour:
- Reset (iRst low, async): state IDLE; all outputs 0; internal seed regs 0; counters 0.
- Taus step (combinational, one per accepted sample), on state s1,s2,s3:
  - b1=((s1<<13)^s1)>>19; s1'=((s1&32'hFFFFFFFE)<<12)^b1
  - b2=((s2<<2)^s2)>>25; s2'=((s2&32'hFFFFFFF8)<<4)^b2
  - b3=((s3<<3)^s3)>>11; s3'=((s3&32'hFFFFFFF0)<<17)^b3
  - expected = s1'^s2'^s3'
  - All shifts are logical, truncated to 32 bits.
- Alignment: sample index 0 is compared against the first step from the raw seeds, matching the generator, which outputs after its first post-reset update.
- FSM:
  - IDLE: oReady=0. On iStart:
    - any seed illegal (s1<2, s2<8, s3<16): set oSeedErr, remain IDLE.
    - otherwise: go to LOAD; clear oDone, oSeedErr, oErrValid, counters and error registers.
  - LOAD (1 cycle): seeds and count registered; oBusy=1; oReady=0; go to RUN.
  - RUN: oBusy=1; oReady=1 except during READY_GAP stall cycles.
    - Transfer happens when iValid&&oReady.
    - On transfer: compare iTaus to expected; advance state regs; increment sample index.
    - On mismatch: increment oMismatchCnt, saturating at all-ones.
    - On the first mismatch only: capture index, expected and got values; set oErrValid.
    - After the transfer with index == count-1: next state DONE.
  - DONE: oDone=1, oBusy=0, oReady=0; results hold. iStart restarts as from IDLE.
- iValid low in RUN: no state change; expected value held.
- iStart during LOAD/RUN: ignored.
- Reset mid-RUN: immediate return to IDLE with all outputs 0.
- Latency: comparison result is visible in oMismatchCnt and error registers one cycle after the transfer. oDone is visible one cycle after the final transfer.
- Sample counter wraps only through the 0 = 2^CNT_W convention; no other wrap is allowed.

Test Plan:
- Seeds 12345/12345/12345, iNumSamples=1000, stream from taus instance with same seeds, iValid always 1 -> oDone after 1000 transfers (+1 cycle), oMismatchCnt=0, oErrValid=0.
- Same setup, bench flips bit 0 of samples 17 and 400 -> oMismatchCnt=2, oFirstErrIdx=17, oFirstErrExp=model[17], oFirstErrGot=model[17]^1.
- iStart with seed1=1 (seeds 2,3 valid) -> oSeedErr=1, oBusy stays 0, oReady stays 0.
- iValid toggled randomly 50%, READY_GAP=3, 200 samples -> exactly 200 transfers counted, oMismatchCnt=0, no sample skipped or duplicated.
- iRst pulsed low at sample 50 of 100, then iStart again with the same seeds -> all outputs 0 during reset; the rerun from index 0 completes with oMismatchCnt=0.
- Stream offset by one sample (generator started one step early), CNT_W=4, iNumSamples=0 -> 16 samples checked, oFirstErrIdx=0, oMismatchCnt=15 (saturates at 15), oDone=1.
